// File: rtl/ps2_key_ctrl_if.sv
// FIFO-side handshake between ps2_keyboard and its host controller.
interface ps2_key_ctrl_if;
  logic [7:0] fifo_data;
  logic       fifo_ready;
  logic       fifo_ovf;
  logic       nextdata_n;

  modport master (
    input  fifo_data,
    input  fifo_ready,
    input  fifo_ovf,
    output nextdata_n
  );

  modport slave (
    output fifo_data,
    output fifo_ready,
    output fifo_ovf,
    input  nextdata_n
  );
endinterface

// File: rtl/ps2_key_ctrl.sv
// Pops scan-code bytes from ps2_keyboard, folds E0/F0 prefixes into key events,
// tracks the held key and counts presses.
module ps2_key_ctrl #(
  parameter int unsigned CNT_W     = 8,
  parameter bit          COUNT_REP = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  ps2_key_ctrl_if.master   fifo,
  input  logic             clr,
  output logic             key_valid,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_brk,
  output logic             key_rep,
  output logic             key_down,
  output logic [CNT_W-1:0] press_count,
  output logic             ovf_sticky
);

  typedef enum logic [1:0] {IDLE, POP, GAP} state_t;

  state_t           state_q, state_d;
  logic [7:0]       byte_q, byte_d;
  logic             pend_ext_q, pend_ext_d;
  logic             pend_brk_q, pend_brk_d;
  logic             nextdata_n_q, nextdata_n_d;
  logic             key_valid_q, key_valid_d;
  logic [7:0]       key_code_q, key_code_d;
  logic             key_ext_q, key_ext_d;
  logic             key_brk_q, key_brk_d;
  logic             key_rep_q, key_rep_d;
  logic             key_down_q, key_down_d;
  logic [7:0]       held_code_q, held_code_d;
  logic             held_ext_q, held_ext_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             inc;
  logic             match;

  always_comb begin
    state_d      = state_q;
    byte_d       = byte_q;
    pend_ext_d   = pend_ext_q;
    pend_brk_d   = pend_brk_q;
    nextdata_n_d = 1'b1;
    key_valid_d  = 1'b0;
    key_code_d   = key_code_q;
    key_ext_d    = key_ext_q;
    key_brk_d    = key_brk_q;
    key_rep_d    = key_rep_q;
    key_down_d   = key_down_q;
    held_code_d  = held_code_q;
    held_ext_d   = held_ext_q;
    inc          = 1'b0;
    match        = (held_code_q == byte_q) && (held_ext_q == pend_ext_q);

    case (state_q)
      IDLE: begin
        if (fifo.fifo_ready) begin
          byte_d       = fifo.fifo_data;
          nextdata_n_d = 1'b0;
          state_d      = POP;
        end
      end
      POP: begin
        state_d = GAP;
        if (byte_q == 8'hE0) begin
          pend_ext_d = 1'b1;
        end else if (byte_q == 8'hF0) begin
          pend_brk_d = 1'b1;
        end else begin
          key_valid_d = 1'b1;
          key_code_d  = byte_q;
          key_ext_d   = pend_ext_q;
          key_brk_d   = pend_brk_q;
          pend_ext_d  = 1'b0;
          pend_brk_d  = 1'b0;
          if (!pend_brk_q) begin
            if (key_down_q && match) begin
              key_rep_d = 1'b1;
              inc       = COUNT_REP;
            end else begin
              key_rep_d   = 1'b0;
              key_down_d  = 1'b1;
              held_code_d = byte_q;
              held_ext_d  = pend_ext_q;
              inc         = 1'b1;
            end
          end else begin
            key_rep_d = 1'b0;
            if (match) key_down_d = 1'b0;
          end
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // clr overrides a same-cycle press increment
    cnt_d = clr ? '0 : cnt_q + {{(CNT_W-1){1'b0}}, inc};
    ovf_d = (ovf_q | fifo.fifo_ovf) & ~clr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      byte_q       <= '0;
      pend_ext_q   <= 1'b0;
      pend_brk_q   <= 1'b0;
      nextdata_n_q <= 1'b1;
      key_valid_q  <= 1'b0;
      key_code_q   <= '0;
      key_ext_q    <= 1'b0;
      key_brk_q    <= 1'b0;
      key_rep_q    <= 1'b0;
      key_down_q   <= 1'b0;
      held_code_q  <= '0;
      held_ext_q   <= 1'b0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_q       <= byte_d;
      pend_ext_q   <= pend_ext_d;
      pend_brk_q   <= pend_brk_d;
      nextdata_n_q <= nextdata_n_d;
      key_valid_q  <= key_valid_d;
      key_code_q   <= key_code_d;
      key_ext_q    <= key_ext_d;
      key_brk_q    <= key_brk_d;
      key_rep_q    <= key_rep_d;
      key_down_q   <= key_down_d;
      held_code_q  <= held_code_d;
      held_ext_q   <= held_ext_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
    end
  end

  assign fifo.nextdata_n = nextdata_n_q;
  assign key_valid       = key_valid_q;
  assign key_code        = key_code_q;
  assign key_ext         = key_ext_q;
  assign key_brk         = key_brk_q;
  assign key_rep         = key_rep_q;
  assign key_down        = key_down_q;
  assign press_count     = cnt_q;
  assign ovf_sticky      = ovf_q;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed bench for ps2_key_ctrl: byte vector table plus burst, wrap, clr, overflow and reset sequences.
module tb_ps2_key_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_brk;
  logic       key_rep;
  logic       key_down;
  logic [7:0] press_count;
  logic       ovf_sticky;

  ps2_key_ctrl_if fif ();

  ps2_key_ctrl #(.CNT_W(8), .COUNT_REP(1'b0)) dut (
    .clk         (clk),
    .rst         (rst),
    .fifo        (fif.master),
    .clr         (clr),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_ext     (key_ext),
    .key_brk     (key_brk),
    .key_rep     (key_rep),
    .key_down    (key_down),
    .press_count (press_count),
    .ovf_sticky  (ovf_sticky)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  fq[$];
  int unsigned pops[$];
  int unsigned cyc = 0;

  // FIFO model: pops on a low nextdata_n, presents head of queue
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (fif.nextdata_n === 1'b0) begin
      pops.push_back(cyc);
      if (fq.size() != 0) void'(fq.pop_front());
    end
    fif.fifo_ready = (fq.size() != 0);
    fif.fifo_data  = (fq.size() != 0) ? fq[0] : 8'h00;
  end

  typedef struct {
    logic [7:0] b;
    logic       ev;
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       rep;
    logic       down;
    logic [7:0] cnt;
  } vec_t;

  vec_t vt[23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_pop(input string name, output bit ok);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (fif.nextdata_n !== 1'b0 && n < 40);
    ok = (fif.nextdata_n === 1'b0);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: no nextdata_n pulse within %0d cycles", name, n);
    end
  endtask

  task automatic apply(input vec_t v, input string name);
    bit ok;
    fq.push_back(v.b);
    wait_pop(name, ok);
    if (!ok) return;
    @(negedge clk);
    chk({name, " key_valid"}, key_valid, v.ev);
    if (v.ev) begin
      chk({name, " key_code"}, key_code, v.code);
      chk({name, " key_ext"}, key_ext, v.ext);
      chk({name, " key_brk"}, key_brk, v.brk);
      chk({name, " key_rep"}, key_rep, v.rep);
    end
    chk({name, " key_down"}, key_down, v.down);
    chk({name, " press_count"}, press_count, v.cnt);
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int n = 0;
    while (!(fq.size() == 0 && fif.nextdata_n === 1'b1) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (n >= max_cyc) begin
      checks++;
      errors++;
      $display("FAIL %s: FIFO not drained after %0d cycles", name, n);
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    vec_t v;
    bit   ok;

    //        byte   ev    code   ext   brk   rep   down  cnt
    vt[0]  = '{8'h1C, 1'b1, 8'h1C, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
    vt[1]  = '{8'h1C, 1'b1, 8'h1C, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1};
    vt[2]  = '{8'h1C, 1'b1, 8'h1C, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1};
    vt[3]  = '{8'hF0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
    vt[4]  = '{8'h1C, 1'b1, 8'h1C, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1};
    vt[5]  = '{8'hE0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
    vt[6]  = '{8'h75, 1'b1, 8'h75, 1'b1, 1'b0, 1'b0, 1'b1, 8'd2};
    vt[7]  = '{8'hE0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2};
    vt[8]  = '{8'hF0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2};
    vt[9]  = '{8'h75, 1'b1, 8'h75, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2};
    vt[10] = '{8'h75, 1'b1, 8'h75, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3};
    vt[11] = '{8'hE0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3};
    vt[12] = '{8'h75, 1'b1, 8'h75, 1'b1, 1'b0, 1'b0, 1'b1, 8'd4};
    vt[13] = '{8'hF0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'd4};
    vt[14] = '{8'hE0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'd4};
    vt[15] = '{8'h75, 1'b1, 8'h75, 1'b1, 1'b1, 1'b0, 1'b0, 8'd4};
    vt[16] = '{8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'd5};
    vt[17] = '{8'hFF, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 8'd6};
    vt[18] = '{8'hF0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'd6};
    vt[19] = '{8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'd6};
    vt[20] = '{8'hF0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'd6};
    vt[21] = '{8'hF0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'd6};
    vt[22] = '{8'hFF, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 8'd6};

    fif.fifo_ovf = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset nextdata_n", fif.nextdata_n, 1'b1);
    chk("reset key_valid", key_valid, 1'b0);
    chk("reset key_code", key_code, 8'h00);
    chk("reset key_down", key_down, 1'b0);
    chk("reset press_count", press_count, 8'd0);
    chk("reset ovf_sticky", ovf_sticky, 1'b0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 23; i++) apply(vt[i], $sformatf("vec%0d", i));

    // Ten queued bytes: pops must be exactly 3 clk apart
    pops.delete();
    fq.push_back(8'h21); fq.push_back(8'hF0); fq.push_back(8'h21);
    fq.push_back(8'h22); fq.push_back(8'hF0); fq.push_back(8'h22);
    fq.push_back(8'h23); fq.push_back(8'hF0); fq.push_back(8'h23);
    fq.push_back(8'h24);
    wait_drain("burst", 200);
    chk("burst pop count", pops.size(), 10);
    for (int i = 1; i < 10; i++)
      if (i < pops.size()) chk($sformatf("burst spacing%0d", i), pops[i] - pops[i-1], 3);
    chk("burst press_count", press_count, 8'd10);
    chk("burst key_down", key_down, 1'b1);
    chk("burst key_code", key_code, 8'h24);

    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr press_count", press_count, 8'd0);

    for (int i = 0; i < 255; i++) begin
      fq.push_back(8'((i % 200) + 1));
      fq.push_back(8'hF0);
      fq.push_back(8'((i % 200) + 1));
    end
    wait_drain("pairs", 10000);
    chk("pairs press_count", press_count, 8'd255);
    chk("pairs key_down", key_down, 1'b0);
    v = '{8'h55, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
    apply(v, "wrap");

    fq.push_back(8'h66);
    wait_pop("clr_inc", ok);
    if (ok) begin
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("clr_inc key_valid", key_valid, 1'b1);
      chk("clr_inc key_code", key_code, 8'h66);
      chk("clr_inc press_count", press_count, 8'd0);
    end

    fif.fifo_ovf = 1'b1;
    @(negedge clk);
    fif.fifo_ovf = 1'b0;
    chk("ovf set", ovf_sticky, 1'b1);
    repeat (5) @(negedge clk);
    chk("ovf held", ovf_sticky, 1'b1);
    fif.fifo_ovf = 1'b1;
    clr = 1'b1;
    @(negedge clk);
    fif.fifo_ovf = 1'b0;
    clr = 1'b0;
    chk("ovf clr wins", ovf_sticky, 1'b0);
    @(negedge clk);
    chk("ovf stays clear", ovf_sticky, 1'b0);

    v = '{8'hE0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
    apply(v, "pre_rst_e0");
    v = '{8'hF0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
    apply(v, "pre_rst_f0");
    rst = 1'b0;
    #1;
    chk("midrst nextdata_n", fif.nextdata_n, 1'b1);
    chk("midrst key_down", key_down, 1'b0);
    chk("midrst key_code", key_code, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    v = '{8'h1C, 1'b1, 8'h1C, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
    apply(v, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
